dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters:
  - the EnDMe core's load/store path;
  - a host port that loads message/key data before a run and dumps results after it.
- Sits between the control unit/datapath and data_mem in top_level.
- Round-robin arbitration, plus a host lock mode for uninterrupted bursts.

Parameters:
- AW, 8, data memory address width.
- DW, 8, data word width.
- MAX_WAIT, 15, starvation limit in cycles. Used only when DMEM_ARB_STARVE_GUARD_EN is defined.

Ports:
- CLK  in  1  system clock, rising edge.
- reset_ctrl  in  1  reset, asynchronous, active-high.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  core access accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  same meanings as the core fields, for the host port.
- host_lock  in  1  host requests exclusive ownership.
- host_gnt, host_rvalid, host_rdata  out  1/1/DW  same meanings as the core outputs, for the host port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- One clock (CLK). Reset is asynchronous, active-high, on reset_ctrl.
- Reset values:
  - state = ARB, last_winner = HOST (so the core has first priority), rd_owner = NONE.
  - All gnt, rvalid, mem_en and mem_we = 0; all rdata = 0.
- While reset_ctrl is high, no grant is given and the memory is not driven.
- Grants are combinational from the current requests and registered state. At most one grant per cycle.
- A grant drives mem_en=1 and copies the winner's we/addr/wdata to the memory port.
- With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- A requester holds req/we/addr/wdata stable until it sees gnt. gnt means accepted; there is no retry.
- Read latency is one cycle:
  - a read granted in cycle N gives owner_rvalid=1 in cycle N+1, with owner_rdata = mem_rdata;
  - rd_owner is registered to steer the data;
  - the non-owner's rdata = 0, as is any rdata whose rvalid is 0;
  - writes never produce rvalid.
- Back-to-back grants are allowed every cycle. A read in N and a write in N+1 both complete.
- State ARB:
  - Only one requester active: it is granted.
  - Both active: grant the requester that is not last_winner.
  - last_winner updates only on a grant.
  - Host granted with host_lock=1: go to HOST_LOCKED.
- State HOST_LOCKED:
  - core_gnt = 0; host_gnt = host_req.
  - host_lock=0: return to ARB, and that cycle's arbitration applies normally (core has priority, since last_winner = HOST).
  - host_lock while in ARB has no effect until the host wins a grant.
- Reset mid-operation: a read in flight is discarded. No rvalid is produced after reset deasserts, and the state returns to ARB.
- Address wrap is left to the memory. The arbiter does no address arithmetic.

Optional Feature:
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- When defined:
  - a counter wait_cnt (width clog2(MAX_WAIT+1)) increments each cycle that core_req=1 and core_gnt=0;
  - wait_cnt clears on core_gnt or reset;
  - when wait_cnt == MAX_WAIT, the core is force-granted that cycle even in HOST_LOCKED, and host_gnt=0;
  - the state stays HOST_LOCKED if host_lock is still 1.
- When undefined: no counter, and the lock is absolute.

Decomposition:
- Shared package endme_pkg holds:
  - typedef enum arb_state_t {ARB, HOST_LOCKED};
  - typedef enum owner_t {OWN_NONE, OWN_CORE, OWN_HOST};
  - constants DMEM_AW=8, DMEM_DW=8.
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin pick from req[1:0] and last_winner.
- The FSM, the rd_owner pipeline register and the optional counter stay in dmem_arbiter.

Test Plan:
- Reset, then idle -> all outputs 0. Assert reset_ctrl mid-read -> no rvalid in the next cycle.
- Core read addr 0x10, memory holds 0xA5 -> core_gnt in cycle N; core_rvalid=1 and core_rdata=0xA5 in N+1; host_rvalid=0.
- Both request every cycle from reset -> grants alternate core, host, core, host. mem_addr follows the winner.
- Host write 0x20=0x3C with lock for 4 cycles while the core requests -> 4 consecutive host_gnt and core_gnt=0. Drop lock -> core_gnt the next cycle.
- Host read then core write back-to-back -> host_rvalid only in cycle 2. Core write completes, no core_rvalid.
- With DMEM_ARB_STARVE_GUARD_EN, MAX_WAIT=3, host locked and the core requesting -> core force-granted on its 4th waiting cycle, host_gnt=0 that cycle. Without the macro, the core waits indefinitely.

Source files
------------

// File: rtl/endme_pkg.sv
// endme_pkg: shared types and constants for the EnDMe data-memory path.
package endme_pkg;

    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned DMEM_DW = 8;

    // Arbiter operating mode.
    typedef enum logic [0:0] {
        ARB         = 1'b0,
        HOST_LOCKED = 1'b1
    } arb_state_t;

    // Requester identity, used both for round-robin history and read steering.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// Bit 0 is the core, bit 1 the host; on contention the side that did not win last goes.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_host,
    output logic [1:0] o_gnt
);

    // Lone requester always wins; on a tie the previous loser wins.
    always_comb begin
        o_gnt    = 2'b00;
        o_gnt[0] = i_req[0] & (~i_req[1] | i_last_host);
        o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last_host);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the core
// load/store path and the host port. Round-robin, plus a host lock for bursts.
// Optional starvation guard for the core: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import endme_pkg::*;
#(
    parameter int unsigned AW       = DMEM_AW,
    parameter int unsigned DW       = DMEM_DW,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          CLK,
    input  logic          reset_ctrl,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_d;
    owner_t     r_last_winner;
    owner_t     w_last_winner_d;
    owner_t     r_rd_owner;
    owner_t     w_rd_owner_d;

    logic [1:0] w_pick;
    logic       w_force;

    rr_pick2 u_rr_pick2 (
        .i_req       ({host_req, core_req}),
        .i_last_host (r_last_winner == OWN_HOST),
        .o_gnt       (w_pick)
    );

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [WaitW-1:0] r_wait_cnt;

    // Core has waited the limit: it goes ahead of everything, the host lock included.
    assign w_force = core_req && (r_wait_cnt == WaitW'(MAX_WAIT));

    // Count cycles the core spends requesting without being accepted.
    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            r_wait_cnt <= '0;
        end else if (core_gnt) begin
            r_wait_cnt <= '0;
        end else if (core_req && (r_wait_cnt != WaitW'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
        end
    end
`else
    // Guard compiled out: the host lock is absolute and MAX_WAIT is not consulted.
    logic w_unused_max_wait;
    assign w_unused_max_wait = ^MAX_WAIT;
    assign w_force           = 1'b0;
`endif

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!reset_ctrl) begin
            if (w_force) begin
                core_gnt = 1'b1;
            end else if ((r_state == HOST_LOCKED) && host_lock) begin
                host_gnt = host_req;
            end else begin
                // Also covers the cycle the host releases the lock.
                core_gnt = w_pick[0];
                host_gnt = w_pick[1];
            end
        end
    end

    // Steer the winner's command onto the memory port; quiet bus otherwise.
    always_comb begin
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Next mode, round-robin history and read-data owner for the following cycle.
    always_comb begin
        w_state_d       = ARB;
        w_last_winner_d = r_last_winner;
        w_rd_owner_d    = OWN_NONE;
        // A forced core grant does not break an ongoing lock.
        if (host_lock && (host_gnt || (r_state == HOST_LOCKED))) begin
            w_state_d = HOST_LOCKED;
        end
        if (core_gnt) begin
            w_last_winner_d = OWN_CORE;
            if (!core_we) begin
                w_rd_owner_d = OWN_CORE;
            end
        end else if (host_gnt) begin
            w_last_winner_d = OWN_HOST;
            if (!host_we) begin
                w_rd_owner_d = OWN_HOST;
            end
        end
    end

    // State registers; last_winner starts as HOST so the core gets first priority.
    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            r_state       <= ARB;
            r_last_winner <= OWN_HOST;
            r_rd_owner    <= OWN_NONE;
        end else begin
            r_state       <= w_state_d;
            r_last_winner <= w_last_winner_d;
            r_rd_owner    <= w_rd_owner_d;
        end
    end

    // Read data goes only to the owner of last cycle's read; zero elsewhere.
    always_comb begin
        core_rvalid = (r_rd_owner == OWN_CORE);
        host_rvalid = (r_rd_owner == OWN_HOST);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

endmodule
